// File: rtl/trace_buffer.sv
// Trace record FIFO between trace_unit and a debug reader. Records are captured on
// trace_ready_i, drained through a req/gnt/rvalid port, and overflow drops are counted.
module trace_buffer #(
   parameter int TRACE_WIDTH = 96,
   parameter int DEPTH       = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       trace_ready_i,
   input  logic [TRACE_WIDTH-1:0]     trace_i,
   input  logic                       clear_i,
   input  logic                       rd_req_i,
   output logic                       rd_gnt_o,
   output logic                       rd_rvalid_o,
   output logic [TRACE_WIDTH-1:0]     rd_rdata_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

   logic [TRACE_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]          level_q, level_d;
   logic                   overflow_q, overflow_d;
   logic [15:0]            drop_q, drop_d;
   rd_state_e              state_q;
   logic                   rvalid_q;
   logic [TRACE_WIDTH-1:0] rdata_q;

   logic empty, full, gnt, wr_en, drop;

   always_comb begin
      empty = (level_q == '0);
      full  = (level_q == LW'(DEPTH));
      // The grant only looks at registered occupancy, so a same-cycle write is never bypassed.
      gnt   = rd_req_i & ~empty & ~clear_i;
      // A pop in the same cycle frees the slot the incoming record needs.
      wr_en = trace_ready_i & ~clear_i & (~full | gnt);
      drop  = trace_ready_i & ~clear_i & full & ~gnt;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (gnt)   rd_ptr_d = rd_ptr_q + AW'(1);

      case ({wr_en, gnt})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end

      if (clear_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= trace_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   // Read response FSM; rdata_q keeps the last returned record until the next grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= R_IDLE;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            R_IDLE: begin
               rvalid_q <= gnt;
               if (gnt) state_q <= R_RESP;
            end
            R_RESP: begin
               rvalid_q <= gnt;
               state_q  <= gnt ? R_RESP : R_IDLE;
            end
            default: begin
               rvalid_q <= 1'b0;
               state_q  <= R_IDLE;
            end
         endcase
         if (gnt) rdata_q <= mem_q[rd_ptr_q];
      end
   end

   assign rd_gnt_o     = gnt;
   assign rd_rvalid_o  = rvalid_q;
   assign rd_rdata_o   = rdata_q;
   assign level_o      = level_q;
   assign empty_o      = empty;
   assign full_o       = full;
   assign overflow_o   = overflow_q;
   assign drop_count_o = drop_q;

endmodule
